// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler: opcode and FSM state
// encodings plus the default WAIT timeout.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_XOR = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo NREQ. Returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IDW = $clog2(NREQ);

  // One extra bit so ptr + k never overflows before the modulo wrap.
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // NOTE: every output and temporary gets a default before the search loop so no
  // path through this block leaves a variable unassigned, which would infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt_idx  = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU among NREQ requesters: round-robin grant, single operation in
// flight, start/done handshake to the ALU and a tagged response with timeout error.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic                    alu_start,
  output logic [1:0]              alu_op,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic                    alu_done,
  input  logic [2*WIDTH-1:0]      alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]      rsp_result,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic [NREQ-1:0] gnt;
  logic           gnt_any;
  logic [CW-1:0]  wait_cnt;
  logic           timeout_hit;
  logic           transfer;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // The grant only ever selects a valid requester, so a grant in IDLE is a transfer.
  assign transfer    = (state == IDLE) && gnt_any;
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (transfer) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (alu_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? gnt : '0;
    alu_start = (state == ISSUE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // NOTE: the datapath registers are reset as well, because the operand and
  // response outputs must read zero straight out of reset, not just the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_id     <= '0;
      wait_cnt   <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            alu_op <= req_op[2*int'(gnt_idx) +: 2];
            alu_a  <= req_a[WIDTH*int'(gnt_idx) +: WIDTH];
            alu_b  <= req_b[WIDTH*int'(gnt_idx) +: WIDTH];
            rsp_id <= gnt_idx;
            rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          // A done arriving on the expiry cycle still counts as success.
          if (alu_done) begin
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
